// File: rtl/ide_autoconfig_if.sv
// Zorro II bus signals exchanged between the CPU side and the IDE AutoConfig responder.
interface ide_autoconfig_if;
  logic [23:1] ADDR;
  logic [3:0]  DIN;
  logic        AS_n;
  logic        UDS_n;
  logic        RW;
  logic        CFGIN_n;
  logic        board_en;
  logic [3:0]  DOUT;
  logic        DOE;
  logic        CFGOUT_n;
  logic        ide_access;
  logic        configured;

  modport master (
    output ADDR, DIN, AS_n, UDS_n, RW, CFGIN_n, board_en,
    input  DOUT, DOE, CFGOUT_n, ide_access, configured
  );

  modport slave (
    input  ADDR, DIN, AS_n, UDS_n, RW, CFGIN_n, board_en,
    output DOUT, DOE, CFGOUT_n, ide_access, configured
  );
endinterface

// File: rtl/ide_autoconfig.sv
// Zorro II AutoConfig responder for the IDE board: serves the config nibbles at $E80000,
// latches the assigned 64K base, then decodes ide_access and passes CFGOUT_n down the chain.
module ide_autoconfig #(
  parameter logic [15:0] MANUFACTURER = 16'd5194,
  parameter logic [7:0]  PRODUCT      = 8'd7,
  parameter logic [31:0] SERIAL       = 32'h0,
  parameter logic [15:0] ROM_VECTOR   = 16'h8000,
  parameter logic [2:0]  SIZE_CODE    = 3'b001
) (
  input  logic            CLK,
  input  logic            RESET,
  ide_autoconfig_if.slave bus
);

  typedef enum logic [1:0] {
    UNCONFIG   = 2'd0,
    CONFIGURED = 2'd1,
    SHUTUP     = 2'd2
  } state_t;

  localparam logic [7:0] ER_TYPE = {2'b11, 1'b0, 1'b1, 1'b0, SIZE_CODE};

  state_t     state_q, state_d;
  logic [7:0] base_q, base_d;
  logic [3:0] base_lo_q, base_lo_d;
  logic       wr_done_q, wr_done_d;
  logic       cfgout_n_q;
  logic       configured_q;

  logic [7:0] offset;
  logic       cfg_hit;
  logic       commit;
  logic       unused_addr;

  // Register bytes sit on 4-byte strides; A1 picks the high (0) or low (1) nibble.
  function automatic logic [3:0] cfg_nibble(input logic [7:1] a);
    logic [7:0] b;
    logic       inv;
    logic [3:0] nib;
    b   = 8'hFF;
    inv = 1'b0;
    case (a[7:2])
      6'h00: begin b = ER_TYPE;            inv = 1'b0; end
      6'h01: begin b = PRODUCT;            inv = 1'b1; end
      6'h02: begin b = 8'h00;              inv = 1'b1; end
      6'h04: begin b = MANUFACTURER[15:8]; inv = 1'b1; end
      6'h05: begin b = MANUFACTURER[7:0];  inv = 1'b1; end
      6'h06: begin b = SERIAL[31:24];      inv = 1'b1; end
      6'h07: begin b = SERIAL[23:16];      inv = 1'b1; end
      6'h08: begin b = SERIAL[15:8];       inv = 1'b1; end
      6'h09: begin b = SERIAL[7:0];        inv = 1'b1; end
      6'h0A: begin b = ROM_VECTOR[15:8];   inv = 1'b1; end
      6'h0B: begin b = ROM_VECTOR[7:0];    inv = 1'b1; end
      6'h10: begin b = 8'h00;              inv = 1'b0; end
      default: begin b = 8'hFF;            inv = 1'b0; end
    endcase
    nib = a[1] ? b[3:0] : b[7:4];
    return inv ? ~nib : nib;
  endfunction

  assign offset      = {bus.ADDR[7:1], 1'b0};
  assign unused_addr = ^bus.ADDR[15:8];

  assign cfg_hit = (state_q == UNCONFIG) && !bus.CFGIN_n &&
                   (bus.ADDR[23:16] == 8'hE8) && !bus.AS_n;
  assign commit  = cfg_hit && !bus.RW && !bus.UDS_n && !wr_done_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    base_lo_d = base_lo_q;
    wr_done_d = wr_done_q;

    if (bus.AS_n) begin
      wr_done_d = 1'b0;
    end

    // One commit per bus cycle; wr_done blocks repeats while AS_n stays low.
    if (commit) begin
      wr_done_d = 1'b1;
      case (offset)
        8'h4A: base_lo_d = bus.DIN;
        8'h48: begin
          base_d  = {bus.DIN, base_lo_q};
          state_d = CONFIGURED;
        end
        8'h4C: state_d = SHUTUP;
        default: ;
      endcase
    end

    // A disabled board drops out of the chain as soon as it is its turn.
    if ((state_q == UNCONFIG) && !bus.CFGIN_n && !bus.board_en) begin
      state_d = SHUTUP;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= UNCONFIG;
      base_q       <= 8'h00;
      base_lo_q    <= 4'h0;
      wr_done_q    <= 1'b0;
      cfgout_n_q   <= 1'b1;
      configured_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      base_lo_q    <= base_lo_d;
      wr_done_q    <= wr_done_d;
      cfgout_n_q   <= (state_d == UNCONFIG);
      configured_q <= (state_d == CONFIGURED);
    end
  end

  assign bus.DOE        = cfg_hit && bus.RW;
  assign bus.DOUT       = (cfg_hit && bus.RW) ? cfg_nibble(bus.ADDR[7:1]) : 4'hF;
  assign bus.CFGOUT_n   = cfgout_n_q;
  assign bus.configured = configured_q;
  assign bus.ide_access = configured_q && (bus.ADDR[23:16] == base_q) && !bus.AS_n;

endmodule

// File: tb/tb_ide_autoconfig.sv
// Bench for ide_autoconfig: a config-ROM table model checked every cycle plus literal directed reads.
module tb_ide_autoconfig;

  localparam logic [15:0] MFR  = 16'd5194;
  localparam logic [7:0]  PROD = 8'd7;
  localparam logic [31:0] SER  = 32'h0;
  localparam logic [15:0] ROMV = 16'h8000;
  localparam logic [2:0]  SIZE = 3'b001;

  localparam int M_UNCFG = 0;
  localparam int M_CONF  = 1;
  localparam int M_SHUT  = 2;

  logic CLK = 1'b0;
  logic RESET;

  ide_autoconfig_if bus();

  ide_autoconfig #(
    .MANUFACTURER(MFR), .PRODUCT(PROD), .SERIAL(SER),
    .ROM_VECTOR(ROMV), .SIZE_CODE(SIZE)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Config ROM as a table of bytes indexed by (offset/4), built straight from the parameters.
  logic [7:0] rb   [0:63];
  bit         rinv [0:63];
  bit         rdef [0:63];

  int         m_state;
  int         m_prev;
  logic [7:0] m_base;
  logic [3:0] m_lo;
  bit         m_wr_done;
  bit         m_live = 1'b0;
  bit         m_hit;
  logic [7:0] m_off;

  function automatic logic [3:0] model_nib(input logic [7:1] a);
    logic [5:0] idx;
    logic [3:0] n;
    idx = a[7:2];
    if (!rdef[idx]) return 4'hF;
    n = a[1] ? rb[idx][3:0] : rb[idx][7:4];
    return rinv[idx] ? ~n : n;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      m_state   = M_UNCFG;
      m_base    = 8'h00;
      m_lo      = 4'h0;
      m_wr_done = 1'b0;
    end else begin
      m_prev = m_state;
      m_off  = {bus.ADDR[7:1], 1'b0};
      m_hit  = (m_state == M_UNCFG) && !bus.CFGIN_n && (bus.ADDR[23:16] == 8'hE8) && !bus.AS_n;
      if (m_hit && !bus.RW && !bus.UDS_n && !m_wr_done) begin
        m_wr_done = 1'b1;
        if (m_off == 8'h4A) m_lo = bus.DIN;
        else if (m_off == 8'h48) begin
          m_base  = {bus.DIN, m_lo};
          m_state = M_CONF;
        end else if (m_off == 8'h4C) m_state = M_SHUT;
      end else if (bus.AS_n) begin
        m_wr_done = 1'b0;
      end
      if (m_prev == M_UNCFG && !bus.CFGIN_n && !bus.board_en) m_state = M_SHUT;
    end
  end

  always @(negedge CLK) begin
    if (m_live) begin
      logic       e_doe;
      logic [3:0] e_dout;
      e_doe  = (m_state == M_UNCFG) && !bus.CFGIN_n && (bus.ADDR[23:16] == 8'hE8) &&
               !bus.AS_n && bus.RW;
      e_dout = e_doe ? model_nib(bus.ADDR[7:1]) : 4'hF;
      chk1("mdl DOE", bus.DOE, e_doe);
      chk4("mdl DOUT", bus.DOUT, e_dout);
      chk1("mdl CFGOUT_n", bus.CFGOUT_n, m_state == M_UNCFG);
      chk1("mdl configured", bus.configured, m_state == M_CONF);
      chk1("mdl ide_access", bus.ide_access,
           (m_state == M_CONF) && (bus.ADDR[23:16] == m_base) && !bus.AS_n);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    bus.AS_n  = 1'b1;
    bus.UDS_n = 1'b1;
    bus.RW    = 1'b1;
    bus.DIN   = 4'h0;
  endtask

  task automatic set_addr(input logic [23:0] a);
    bus.ADDR = a[23:1];
  endtask

  task automatic rd(input string nm, input logic [23:0] a, input logic [3:0] e_d,
                    input logic e_doe, input logic e_acc);
    tick();
    set_addr(a);
    bus.RW    = 1'b1;
    bus.AS_n  = 1'b0;
    bus.UDS_n = 1'b0;
    #2;
    chk4({nm, " DOUT"}, bus.DOUT, e_d);
    chk1({nm, " DOE"}, bus.DOE, e_doe);
    chk1({nm, " ide_access"}, bus.ide_access, e_acc);
    tick();
    idle();
  endtask

  task automatic wr(input logic [23:0] a, input logic [3:0] d, input int hold);
    tick();
    set_addr(a);
    bus.RW    = 1'b0;
    bus.AS_n  = 1'b0;
    bus.UDS_n = 1'b0;
    bus.DIN   = d;
    for (int i = 1; i < hold; i++) begin
      tick();
      bus.DIN = d + 4'(i);
    end
    tick();
    idle();
  endtask

  task automatic pulse_reset();
    tick();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      rb[i] = 8'hFF; rinv[i] = 1'b0; rdef[i] = 1'b0;
    end
    rb[0]  = {2'b11, 1'b0, 1'b1, 1'b0, SIZE}; rdef[0] = 1'b1;
    rb[1]  = PROD;        rinv[1]  = 1'b1; rdef[1]  = 1'b1;
    rb[2]  = 8'h00;       rinv[2]  = 1'b1; rdef[2]  = 1'b1;
    rb[4]  = MFR[15:8];   rinv[4]  = 1'b1; rdef[4]  = 1'b1;
    rb[5]  = MFR[7:0];    rinv[5]  = 1'b1; rdef[5]  = 1'b1;
    rb[6]  = SER[31:24];  rinv[6]  = 1'b1; rdef[6]  = 1'b1;
    rb[7]  = SER[23:16];  rinv[7]  = 1'b1; rdef[7]  = 1'b1;
    rb[8]  = SER[15:8];   rinv[8]  = 1'b1; rdef[8]  = 1'b1;
    rb[9]  = SER[7:0];    rinv[9]  = 1'b1; rdef[9]  = 1'b1;
    rb[10] = ROMV[15:8];  rinv[10] = 1'b1; rdef[10] = 1'b1;
    rb[11] = ROMV[7:0];   rinv[11] = 1'b1; rdef[11] = 1'b1;
    rb[16] = 8'h00;       rdef[16] = 1'b1;

    RESET        = 1'b1;
    bus.ADDR     = '0;
    bus.CFGIN_n  = 1'b0;
    bus.board_en = 1'b1;
    idle();
    tick();
    m_live = 1'b1;
    tick();
    chk1("reset DOE", bus.DOE, 1'b0);
    chk1("reset CFGOUT_n", bus.CFGOUT_n, 1'b1);
    chk1("reset configured", bus.configured, 1'b0);
    chk1("reset ide_access", bus.ide_access, 1'b0);
    chk4("reset DOUT", bus.DOUT, 4'hF);
    RESET = 1'b0;

    // Literal ROM reads with default parameters.
    rd("er_Type hi", 24'hE80000, 4'hD, 1'b1, 1'b0);
    rd("er_Type lo", 24'hE80002, 4'h1, 1'b1, 1'b0);
    rd("product hi", 24'hE80004, 4'hF, 1'b1, 1'b0);
    rd("product lo", 24'hE80006, 4'h8, 1'b1, 1'b0);
    rd("mfr 10", 24'hE80010, 4'hE, 1'b1, 1'b0);
    rd("mfr 12", 24'hE80012, 4'hB, 1'b1, 1'b0);
    rd("mfr 14", 24'hE80014, 4'hB, 1'b1, 1'b0);
    rd("mfr 16", 24'hE80016, 4'h5, 1'b1, 1'b0);
    rd("serial 18", 24'hE80018, 4'hF, 1'b1, 1'b0);
    rd("romvec 28", 24'hE80028, 4'h7, 1'b1, 1'b0);
    rd("romvec 2A", 24'hE8002A, 4'hF, 1'b1, 1'b0);
    rd("unused 0C", 24'hE8000C, 4'hF, 1'b1, 1'b0);
    rd("reg 40", 24'hE80040, 4'h0, 1'b1, 1'b0);
    rd("reg 42", 24'hE80042, 4'h0, 1'b1, 1'b0);
    rd("reg 44", 24'hE80044, 4'hF, 1'b1, 1'b0);

    // Configure at $E9.
    wr(24'hE8004A, 4'h9, 1);
    chk1("after 4A configured", bus.configured, 1'b0);
    wr(24'hE80048, 4'hE, 1);
    chk1("cfg E9 configured", bus.configured, 1'b1);
    chk1("cfg E9 CFGOUT_n", bus.CFGOUT_n, 1'b0);
    rd("win E9", 24'hE90000, 4'hF, 1'b0, 1'b1);
    rd("old E8", 24'hE80000, 4'hF, 1'b0, 1'b0);

    // Reset while configured; base_lo must also have cleared.
    pulse_reset();
    chk1("rst CFGOUT_n", bus.CFGOUT_n, 1'b1);
    chk1("rst configured", bus.configured, 1'b0);
    rd("rst E9", 24'hE90000, 4'hF, 1'b0, 1'b0);
    wr(24'hE80048, 4'h5, 1);
    rd("base 50", 24'h500000, 4'hF, 1'b0, 1'b1);
    rd("base not 59", 24'h590000, 4'hF, 1'b0, 1'b0);

    // Long write cycles: only the first-cycle nibble lands.
    pulse_reset();
    wr(24'hE8004A, 4'h7, 5);
    wr(24'hE80048, 4'h2, 5);
    rd("hold 27", 24'h270000, 4'hF, 1'b0, 1'b1);
    rd("hold not 2B", 24'h2B0000, 4'hF, 1'b0, 1'b0);
    rd("hold not 67", 24'h670000, 4'hF, 1'b0, 1'b0);

    // Shut-up by register write; sticky.
    pulse_reset();
    wr(24'hE8004C, 4'h0, 1);
    chk1("shut CFGOUT_n", bus.CFGOUT_n, 1'b0);
    chk1("shut configured", bus.configured, 1'b0);
    rd("shut E8", 24'hE80000, 4'hF, 1'b0, 1'b0);
    wr(24'hE80048, 4'h0, 1);
    chk1("shut sticky", bus.configured, 1'b0);
    rd("shut 00", 24'h000000, 4'hF, 1'b0, 1'b0);

    // Not our turn in the chain.
    pulse_reset();
    bus.CFGIN_n = 1'b1;
    wr(24'hE80048, 4'hE, 1);
    chk1("cfgin CFGOUT_n", bus.CFGOUT_n, 1'b1);
    chk1("cfgin configured", bus.configured, 1'b0);
    rd("cfgin E8", 24'hE80000, 4'hF, 1'b0, 1'b0);
    bus.CFGIN_n = 1'b0;

    // Board jumpered off.
    pulse_reset();
    bus.board_en = 1'b0;
    tick();
    chk1("board_en CFGOUT_n", bus.CFGOUT_n, 1'b0);
    chk1("board_en configured", bus.configured, 1'b0);
    bus.board_en = 1'b1;
    rd("board_en E8", 24'hE80000, 4'hF, 1'b0, 1'b0);

    // Base $E8 is a legal assignment.
    pulse_reset();
    wr(24'hE8004A, 4'h8, 1);
    wr(24'hE80048, 4'hE, 1);
    rd("base E8", 24'hE80000, 4'hF, 1'b0, 1'b1);
    rd("base E8 odd", 24'hE81232, 4'hF, 1'b0, 1'b1);

    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
